// File: rtl/vehicle_pkg.sv
// Shared vehicle-side constants and types: distance width, default
// 50 MHz ranging timings and the ultrasonic ranger state encoding.
package vehicle_pkg;

  localparam int CM_W = 9;

  localparam int DEF_TRIG_CYCLES      = 500;
  localparam int DEF_CYCLES_PER_CM    = 2900;
  localparam int DEF_MAX_CM           = 400;
  localparam int DEF_ECHO_WAIT_CYCLES = 1_500_000;
  localparam int DEF_PERIOD_CYCLES    = 3_000_000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    HOLDOFF   = 3'd4
  } ranger_state_t;

endpackage

// File: rtl/ultrasonic_ranger_if.sv
// Sensor-side and result-side signals of one ultrasonic ranger.
// Handshake: dataValid is a one-cycle strobe with no ready/backpressure.
// SensorInCM and timeout change only in the cycle dataValid is high and
// hold until the next strobe, so a consumer may sample them on dataValid
// or read them at any later time.
interface ultrasonic_ranger_if;
  logic                           ENABLE;
  logic                           ECHO;
  logic                           TRIG;
  logic [vehicle_pkg::CM_W-1:0]   SensorInCM;
  logic                           dataValid;
  logic                           timeout;
  logic                           busy;
  vehicle_pkg::ranger_state_t     state;

  modport master (
    input  ENABLE, ECHO,
    output TRIG, SensorInCM, dataValid, timeout, busy, state
  );

  modport slave (
    output ENABLE, ECHO,
    input  TRIG, SensorInCM, dataValid, timeout, busy, state
  );
endinterface

// File: rtl/echo_sync.sv
// Two-flop synchroniser for an asynchronous level, plus registered
// single-cycle rise/fall pulses. Pin-to-pulse latency is three clocks
// for both edges, so pulse spacing equals the pin high/low width.
module echo_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q, rise_q, fall_q;

  // Synchronise the pin and register edge pulses off the clean level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: fires TRIG, times the echo high width and
// publishes whole centimetres (or MAX_CM with timeout on no echo/overrun).
module ultrasonic_ranger
  import vehicle_pkg::*;
#(
  parameter int TRIG_CYCLES      = DEF_TRIG_CYCLES,
  parameter int CYCLES_PER_CM    = DEF_CYCLES_PER_CM,
  parameter int MAX_CM           = DEF_MAX_CM,
  parameter int ECHO_WAIT_CYCLES = DEF_ECHO_WAIT_CYCLES,
  parameter int PERIOD_CYCLES    = DEF_PERIOD_CYCLES
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  ultrasonic_ranger_if.master bus
);

  localparam int CNT_W = $clog2(PERIOD_CYCLES);
  localparam int SUB_W = $clog2(CYCLES_PER_CM);

  localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(ECHO_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [SUB_W-1:0] SUB_LAST    = SUB_W'(CYCLES_PER_CM - 1);
  localparam logic [CM_W-1:0]  MAX_CM_V    = CM_W'(MAX_CM);

  ranger_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [CM_W-1:0]  cm_q, cm_d;
  logic             armed_q, armed_d;
  logic             trig_q, trig_d;
  logic [CM_W-1:0]  dist_q, dist_d;
  logic             valid_q, valid_d;
  logic             tout_q, tout_d;
  logic             busy_q, busy_d;

  logic echo_lvl, echo_rise, echo_fall;

  echo_sync u_echo_sync (
    .clk_i   (CLOCK_50),
    .rst_ni  (RESET_N),
    .async_i (bus.ECHO),
    .level_o (echo_lvl),
    .rise_o  (echo_rise),
    .fall_o  (echo_fall)
  );

  // A rise only counts once the synchronised echo has been seen low inside
  // WAIT_ECHO, so an echo already high when TRIG drops is ignored.
  logic rise_ok, trig_done, wait_expired, sub_wrap, overrun, hold_done;
  assign rise_ok      = echo_rise & armed_q;
  assign trig_done    = (cnt_q == TRIG_LAST);
  assign wait_expired = (cnt_q == WAIT_LAST);
  assign sub_wrap     = (sub_q == SUB_LAST);
  assign overrun      = sub_wrap & (cm_q == MAX_CM_V);
  assign hold_done    = (period_q == PERIOD_LAST) & ~echo_lvl;

  // State register.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.ENABLE) state_d = TRIG;
      TRIG:      if (trig_done) state_d = WAIT_ECHO;
      WAIT_ECHO: begin
        if (rise_ok)           state_d = MEASURE;
        else if (wait_expired) state_d = HOLDOFF;
      end
      MEASURE:   if (overrun || echo_fall) state_d = HOLDOFF;
      HOLDOFF:   if (hold_done) state_d = bus.ENABLE ? TRIG : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Counter and registered-output next values.
  always_comb begin
    cnt_d    = cnt_q;
    sub_d    = sub_q;
    cm_d     = cm_q;
    armed_d  = armed_q;
    dist_d   = dist_q;
    tout_d   = tout_q;
    valid_d  = 1'b0;
    trig_d   = (state_d == TRIG);
    busy_d   = (state_d != IDLE);
    // Period counter saturates so long overruns cannot wrap it.
    period_d = (period_q == PERIOD_LAST) ? period_q : period_q + CNT_W'(1);
    if (state_q != TRIG && state_d == TRIG) begin
      period_d = '0;
      cnt_d    = '0;
    end
    case (state_q)
      TRIG: begin
        cnt_d   = trig_done ? '0 : cnt_q + CNT_W'(1);
        armed_d = 1'b0;
      end
      WAIT_ECHO: begin
        if (!echo_lvl) armed_d = 1'b1;
        if (rise_ok) begin
          sub_d = '0;
          cm_d  = '0;
        end else if (wait_expired) begin
          dist_d  = MAX_CM_V;
          tout_d  = 1'b1;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MEASURE: begin
        if (overrun) begin
          dist_d  = MAX_CM_V;
          tout_d  = 1'b1;
          valid_d = 1'b1;
        end else if (echo_fall) begin
          // The fall cycle itself completes a centimetre when sub is at its top.
          dist_d  = cm_q + CM_W'(sub_wrap);
          tout_d  = 1'b0;
          valid_d = 1'b1;
        end else if (sub_wrap) begin
          sub_d = '0;
          cm_d  = cm_q + CM_W'(1);
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q    <= '0;
      period_q <= '0;
      sub_q    <= '0;
      cm_q     <= '0;
      armed_q  <= 1'b0;
      trig_q   <= 1'b0;
      dist_q   <= MAX_CM_V;
      valid_q  <= 1'b0;
      tout_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      sub_q    <= sub_d;
      cm_q     <= cm_d;
      armed_q  <= armed_d;
      trig_q   <= trig_d;
      dist_q   <= dist_d;
      valid_q  <= valid_d;
      tout_q   <= tout_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.TRIG       = trig_q;
  assign bus.SensorInCM = dist_q;
  assign bus.dataValid  = valid_q;
  assign bus.timeout    = tout_q;
  assign bus.busy       = busy_q;
  assign bus.state      = state_q;

endmodule
